bola_nave: RTL and testbench

- Player-shot generator. Launches one bullet from the ship's muzzle on a fire press and moves it up the screen at a fixed pixel step per game tick.
- Publishes bola_nave_x/bola_nave_y, which every enemy instance consumes for its hit-box test.
- Retires the bullet at the top edge or on a hit reported by the top level.
- Sits between the ship/button logic and the enemy array.

---
 rtl/bola_nave_pkg.sv | 22 ++
 rtl/bola_nave_divisor_tick.sv | 39 +++
 rtl/bola_nave.sv | 155 +++++++++++++++
 tb/tb_bola_nave.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bola_nave_pkg.sv
// Definitions shared by the shot, enemy and ship blocks: screen geometry,
// the common state encoding and the x-clamp used when a bullet is launched.
package bola_nave_pkg;

    localparam int LARGURA_TELA = 640;
    localparam int ALTURA_TELA  = 480;

    typedef enum logic [1:0] {
        OCIOSA  = 2'd0,
        VOANDO  = 2'd1,
        RECARGA = 2'd2
    } estado_t;

    function automatic logic [9:0] limita_x(input logic [10:0] v);
        if (v > 11'(LARGURA_TELA - 1)) begin
            return 10'(LARGURA_TELA - 1);
        end else begin
            return v[9:0];
        end
    endfunction

endpackage

// File: rtl/bola_nave_divisor_tick.sv
// Game-tick divider: counts CLOCK_50 cycles and pulses tick for one cycle
// each time the count wraps. The count freezes while the game is paused.
module divisor_tick
    import bola_nave_pkg::*;
#(
    parameter int DIV_TICK = 250000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic reiniciarJogo,
    input  logic pausa,
    output logic tick
);

    localparam int            CW     = (DIV_TICK > 1) ? $clog2(DIV_TICK) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(DIV_TICK - 1);

    logic [CW-1:0] r_cnt;

    // Tick counter, held while paused
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (reiniciarJogo) begin
            r_cnt <= '0;
        end else if (!pausa) begin
            if (r_cnt == ULTIMO) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign tick = ~pausa & (r_cnt == ULTIMO);

endmodule

// File: rtl/bola_nave.sv
// Player shot: launches one bullet from the ship muzzle on a fire press,
// climbs it PASSO_Y pixels per tick, and retires it at the top or on a hit.
module bola_nave
    import bola_nave_pkg::*;
#(
    parameter int DIV_TICK      = 250000,
    parameter int PASSO_Y       = 8,
    parameter int Y_NAVE        = 440,
    parameter int LARGURA_NAVE  = 32,
    parameter int RECARGA_TICKS = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       pausa,
    input  logic       reiniciarJogo,
    input  logic       disparo,
    input  logic [9:0] nave_x,
    input  logic       acerto,
    output logic [9:0] bola_nave_x,
    output logic [9:0] bola_nave_y,
    output logic       ativa,
    output logic [7:0] tiros
);

    localparam int             RW          = (RECARGA_TICKS > 0) ? $clog2(RECARGA_TICKS + 1) : 1;
    localparam logic [RW-1:0]  RECARGA_INI = RW'(RECARGA_TICKS);
    localparam logic [9:0]     Y_LANCA     = 10'(Y_NAVE - 1);
    localparam logic [9:0]     PASSO       = 10'(PASSO_Y);
    localparam logic [10:0]    MEIO_NAVE   = 11'(LARGURA_NAVE / 2);

    estado_t       r_estado, w_estado;
    logic [9:0]    r_x, w_x;
    logic [9:0]    r_y, w_y;
    logic          r_ativa, w_ativa;
    logic [7:0]    r_tiros, w_tiros;
    logic [RW-1:0] r_recarga, w_recarga;
    logic          r_sinc0, r_sinc1, r_ant;
    logic          w_tick, w_borda;

    divisor_tick #(.DIV_TICK(DIV_TICK)) u_divisor_tick (
        .CLOCK_50      (CLOCK_50),
        .reset         (reset),
        .reiniciarJogo (reiniciarJogo),
        .pausa         (pausa),
        .tick          (w_tick)
    );

    // Fire button synchronizer; r_ant tracks even during pause so a held press never fires late
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_sinc0 <= 1'b0;
            r_sinc1 <= 1'b0;
            r_ant   <= 1'b0;
        end else if (reiniciarJogo) begin
            r_sinc0 <= 1'b0;
            r_sinc1 <= 1'b0;
            r_ant   <= 1'b0;
        end else begin
            r_sinc0 <= disparo;
            r_sinc1 <= r_sinc0;
            r_ant   <= r_sinc1;
        end
    end

    assign w_borda = r_sinc1 & ~r_ant;

    // State and output registers
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            r_estado  <= OCIOSA;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_ativa   <= 1'b0;
            r_tiros   <= 8'd0;
            r_recarga <= '0;
        end else if (reiniciarJogo) begin
            r_estado  <= OCIOSA;
            r_x       <= 10'd0;
            r_y       <= 10'd0;
            r_ativa   <= 1'b0;
            r_tiros   <= 8'd0;
            r_recarga <= '0;
        end else begin
            r_estado  <= w_estado;
            r_x       <= w_x;
            r_y       <= w_y;
            r_ativa   <= w_ativa;
            r_tiros   <= w_tiros;
            r_recarga <= w_recarga;
        end
    end

    // Next state; a retired bullet parks at (0,0) so no enemy can see it as a hit
    always_comb begin
        w_estado  = r_estado;
        w_x       = r_x;
        w_y       = r_y;
        w_ativa   = r_ativa;
        w_tiros   = r_tiros;
        w_recarga = r_recarga;
        case (r_estado)
            OCIOSA: begin
                if (w_borda && !pausa) begin
                    w_estado = VOANDO;
                    w_x      = limita_x({1'b0, nave_x} + MEIO_NAVE);
                    w_y      = Y_LANCA;
                    w_ativa  = 1'b1;
                    if (r_tiros != 8'hFF) begin
                        w_tiros = r_tiros + 8'd1;
                    end else begin
                        w_tiros = r_tiros;
                    end
                end else begin
                    w_estado = OCIOSA;
                end
            end
            VOANDO: begin
                // The top-edge test precedes the subtract so y never wraps
                if (acerto || (w_tick && (r_y < PASSO))) begin
                    w_estado  = RECARGA;
                    w_x       = 10'd0;
                    w_y       = 10'd0;
                    w_ativa   = 1'b0;
                    w_recarga = RECARGA_INI;
                end else if (w_tick) begin
                    w_y = r_y - PASSO;
                end else begin
                    w_y = r_y;
                end
            end
            RECARGA: begin
                if (r_recarga == '0) begin
                    w_estado = OCIOSA;
                end else if (w_tick) begin
                    w_recarga = r_recarga - RW'(1);
                end else begin
                    w_recarga = r_recarga;
                end
            end
            default: begin
                w_estado  = OCIOSA;
                w_x       = 10'd0;
                w_y       = 10'd0;
                w_ativa   = 1'b0;
                w_recarga = '0;
            end
        endcase
    end

    assign bola_nave_x = r_x;
    assign bola_nave_y = r_y;
    assign ativa       = r_ativa;
    assign tiros       = r_tiros;

endmodule

// File: tb/tb_bola_nave.sv
// Self-checking bench for bola_nave: table-driven launch cases, directed
// corner sequences and random stimulus against a cycle-level behavioural model.
module tb_bola_nave;

    localparam int DIV   = 4;
    localparam int PASSO = 8;
    localparam int YN    = 440;
    localparam int LN    = 32;
    localparam int REC   = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b0;
    logic       pausa = 1'b0;
    logic       reiniciarJogo = 1'b0;
    logic       disparo = 1'b0;
    logic [9:0] nave_x = 10'd0;
    logic       acerto = 1'b0;
    logic [9:0] bola_nave_x, bola_nave_y;
    logic       ativa;
    logic [7:0] tiros;

    bola_nave #(
        .DIV_TICK(DIV), .PASSO_Y(PASSO), .Y_NAVE(YN),
        .LARGURA_NAVE(LN), .RECARGA_TICKS(REC)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .pausa(pausa),
        .reiniciarJogo(reiniciarJogo), .disparo(disparo), .nave_x(nave_x),
        .acerto(acerto), .bola_nave_x(bola_nave_x), .bola_nave_y(bola_nave_y),
        .ativa(ativa), .tiros(tiros)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: bullet flying flag, cooldown (-1 = ready), position, shot count
    int m_cnt;
    bit m_s0, m_s1, m_ant;
    bit m_voa;
    int m_rec;
    int m_x, m_y, m_tiros;

    typedef struct {
        logic [9:0] nx;
        int         exp_x;
        int         exp_y;
    } caso_t;

    task automatic check(input string nome, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nome, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_s0 = 0; m_s1 = 0; m_ant = 0;
        m_voa = 0; m_rec = -1; m_x = 0; m_y = 0; m_tiros = 0;
    endtask

    task automatic model_advance();
        bit tk, bd;
        int cx;
        tk = !pausa && (m_cnt == DIV - 1);
        bd = m_s1 && !m_ant;
        if (reiniciarJogo) begin
            model_reset();
        end else begin
            if (!m_voa && m_rec < 0) begin
                if (bd && !pausa) begin
                    cx = int'(nave_x) + LN / 2;
                    m_x = (cx > 639) ? 639 : cx;
                    m_y = YN - 1;
                    m_voa = 1;
                    if (m_tiros < 255) m_tiros++;
                end
            end else if (m_voa) begin
                if (acerto || (tk && m_y < PASSO)) begin
                    m_voa = 0; m_x = 0; m_y = 0; m_rec = REC;
                end else if (tk) begin
                    m_y -= PASSO;
                end
            end else begin
                if (m_rec == 0) m_rec = -1;
                else if (tk) m_rec--;
            end
            if (!pausa) m_cnt = (m_cnt + 1) % DIV;
            m_ant = m_s1; m_s1 = m_s0; m_s0 = disparo;
        end
    endtask

    // One clock: advance the model, let the edge happen, compare on the falling edge
    task automatic step();
        model_advance();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("model_x", bola_nave_x, m_x);
        check("model_y", bola_nave_y, m_y);
        check("model_ativa", ativa, m_voa);
        check("model_tiros", tiros, m_tiros);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic fire_pulse();
        disparo = 1'b1; step();
        disparo = 1'b0; step(); step();
    endtask

    task automatic retire();
        acerto = 1'b1; step();
        acerto = 1'b0; steps(12);
    endtask

    caso_t casos[6];
    int ult, k, t0, y0;

    initial begin
        casos[0] = '{10'd100,  116, 439};
        casos[1] = '{10'd0,    16,  439};
        casos[2] = '{10'd623,  639, 439};
        casos[3] = '{10'd624,  639, 439};
        casos[4] = '{10'd630,  639, 439};
        casos[5] = '{10'd1023, 639, 439};

        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check("reset_x", bola_nave_x, 0);
        check("reset_y", bola_nave_y, 0);
        check("reset_ativa", ativa, 0);
        check("reset_tiros", tiros, 0);
        reset = 1'b1;
        model_reset();

        // First shot: latency and position
        nave_x = 10'd100;
        disparo = 1'b1; step();
        disparo = 1'b0; step();
        check("latency_early", ativa, 0);
        step();
        check("launch_ativa", ativa, 1);
        check("launch_x", bola_nave_x, 116);
        check("launch_y", bola_nave_y, 439);
        check("launch_tiros", tiros, 1);
        steps(16);
        check("four_ticks_y", bola_nave_y, 407);

        // Unhit flight to the top edge
        ult = bola_nave_y;
        k = 0;
        while (ativa && k < 400) begin
            ult = bola_nave_y;
            step();
            k++;
        end
        check("top_timeout", ativa, 0);
        check("top_last_y", ult, 7);
        check("top_park_x", bola_nave_x, 0);
        check("top_park_y", bola_nave_y, 0);

        // Press during cooldown is dropped; press after cooldown fires
        disparo = 1'b1; step();
        disparo = 1'b0; steps(3);
        check("cooldown_no_fire", ativa, 0);
        steps(12);
        fire_pulse();
        check("after_cooldown_ativa", ativa, 1);
        check("after_cooldown_tiros", tiros, 2);

        // Hit coincident with a tick: parks without decrementing first
        k = 0;
        while (m_cnt != DIV - 1 && k < 8) begin step(); k++; end
        acerto = 1'b1; step();
        acerto = 1'b0;
        check("hit_tick_x", bola_nave_x, 0);
        check("hit_tick_y", bola_nave_y, 0);
        check("hit_tick_ativa", ativa, 0);
        steps(12);

        // Launch column table, and x held while the ship moves
        for (int i = 0; i < 6; i++) begin
            nave_x = casos[i].nx;
            fire_pulse();
            check("table_ativa", ativa, 1);
            check("table_x", bola_nave_x, casos[i].exp_x);
            check("table_y", bola_nave_y, casos[i].exp_y);
            nave_x = ~casos[i].nx;
            steps(8);
            check("table_x_held", bola_nave_x, casos[i].exp_x);
            retire();
        end

        // Held button fires exactly once
        t0 = tiros;
        disparo = 1'b1; steps(100);
        disparo = 1'b0;
        check("held_one_shot", tiros, t0 + 1);
        check("held_ativa", ativa, 1);
        retire();

        // Pause mid-flight freezes y
        fire_pulse();
        steps(5);
        y0 = bola_nave_y;
        pausa = 1'b1; steps(50);
        check("pause_y_frozen", bola_nave_y, y0);
        pausa = 1'b0; steps(10);
        retire();

        // Press inside a pause, released or held, never fires afterwards
        t0 = tiros;
        pausa = 1'b1; disparo = 1'b1; steps(5);
        disparo = 1'b0; steps(5);
        pausa = 1'b0; steps(10);
        check("pause_press_ativa", ativa, 0);
        check("pause_press_tiros", tiros, t0);
        pausa = 1'b1; disparo = 1'b1; steps(5);
        pausa = 1'b0; steps(10);
        disparo = 1'b0;
        check("pause_held_ativa", ativa, 0);
        steps(3);

        // Asynchronous reset mid-flight
        fire_pulse();
        steps(10);
        #2 reset = 1'b0;
        #1;
        check("async_x", bola_nave_x, 0);
        check("async_y", bola_nave_y, 0);
        check("async_ativa", ativa, 0);
        check("async_tiros", tiros, 0);
        model_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;

        // Synchronous restart
        fire_pulse();
        retire();
        fire_pulse();
        reiniciarJogo = 1'b1; step();
        reiniciarJogo = 1'b0;
        check("restart_tiros", tiros, 0);
        check("restart_ativa", ativa, 0);
        check("restart_y", bola_nave_y, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            disparo       = ($urandom_range(0, 3) == 0);
            acerto        = ($urandom_range(0, 15) == 0);
            nave_x        = 10'($urandom_range(0, 1023));
            reiniciarJogo = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 19) == 0) pausa = ~pausa;
            step();
        end
        disparo = 1'b0; acerto = 1'b0; pausa = 1'b0; reiniciarJogo = 1'b0;

        // Shot counter saturation
        reiniciarJogo = 1'b1; step();
        reiniciarJogo = 1'b0;
        for (int i = 0; i < 300; i++) begin
            fire_pulse();
            retire();
        end
        check("saturate_tiros", tiros, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
